// File: rtl/intersection_signal_pkg.sv
// rtl/intersection_signal_pkg.sv - shared state codes and lamp patterns for the intersection controller
package intersection_signal_pkg;

    typedef enum logic [2:0] {
        S_AR2  = 3'd0,
        S_A_G  = 3'd1,
        S_A_Y  = 3'd2,
        S_AR1  = 3'd3,
        S_B_G  = 3'd4,
        S_B_Y  = 3'd5,
        S_PED  = 3'd6,
        S_FLSH = 3'd7
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

endpackage

// File: rtl/intersection_signal_if.sv
// rtl/intersection_signal_if.sv - request inputs and lamp outputs of the intersection controller
interface intersection_signal_if;
    logic       FLASH;
    logic       PED_REQ;
    logic [2:0] LED_A;
    logic [2:0] LED_B;
    logic       PED_WALK;
    logic       PED_PENDING;
    logic [2:0] STATE;

    modport master (
        output FLASH, PED_REQ,
        input  LED_A, LED_B, PED_WALK, PED_PENDING, STATE
    );

    modport slave (
        input  FLASH, PED_REQ,
        output LED_A, LED_B, PED_WALK, PED_PENDING, STATE
    );
endinterface

// File: rtl/intersection_signal_ms_tick_gen.sv
// rtl/intersection_signal_ms_tick_gen.sv - millisecond prescaler, restartable on phase entry
module ms_tick_gen #(
    parameter int CLK_FREQ = 12000000,
    parameter int CNT_W    = 32
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CLR,
    output logic TICK
);
    localparam int              DIV    = CLK_FREQ / 1000;
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign TICK = (cnt == DIV_M1);

    always_ff @(posedge CLK) begin
        if (!RST_N || CLR) begin
            cnt <= '0;
        end else if (TICK) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/intersection_signal.sv
// rtl/intersection_signal.sv - two-road signal FSM with ped request latch and night flash mode
module intersection_signal
    import intersection_signal_pkg::*;
#(
    parameter int CLK_FREQ     = 12000000,
    parameter int G_PERIOD_MS  = 5000,
    parameter int MIN_G_MS     = 2000,
    parameter int Y_PERIOD_MS  = 1000,
    parameter int AR_PERIOD_MS = 1000,
    parameter int PED_MS       = 4000,
    parameter int FLASH_MS     = 500,
    parameter int CNT_W        = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    intersection_signal_if.slave io
);
    localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(G_PERIOD_MS - 1);
    localparam logic [CNT_W-1:0] MIN_G   = CNT_W'(MIN_G_MS);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(Y_PERIOD_MS - 1);
    localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(AR_PERIOD_MS - 1);
    localparam logic [CNT_W-1:0] P_LAST  = CNT_W'(PED_MS - 1);
    localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(FLASH_MS - 1);
    localparam logic [CNT_W-1:0] MS_MAX  = '1;

    state_t           state, state_next;
    logic [CNT_W-1:0] ms;
    logic             tick, clr, pending, phase;
    logic [2:0]       led_a, led_b;
    logic             walk;

    // Any state change restarts both the prescaler and the ms counter.
    assign clr = (state_next != state);

    ms_tick_gen #(.CLK_FREQ(CLK_FREQ), .CNT_W(CNT_W)) u_tick (
        .CLK  (CLK),
        .RST_N(RST_N),
        .CLR  (clr),
        .TICK (tick)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= S_AR2;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        led_a      = RED;
        led_b      = RED;
        walk       = 1'b0;
        case (state)
            S_AR2:  if (tick && ms == AR_LAST)
                        state_next = io.FLASH ? S_FLSH : (pending ? S_PED : S_A_G);
            S_A_G: begin
                led_a = GRN;
                if ((tick && ms == G_LAST) || (pending && ms >= MIN_G)) state_next = S_A_Y;
            end
            S_A_Y: begin
                led_a = YEL;
                if (tick && ms == Y_LAST) state_next = S_AR1;
            end
            S_AR1:  if (tick && ms == AR_LAST) state_next = io.FLASH ? S_FLSH : S_B_G;
            S_B_G: begin
                led_b = GRN;
                if ((tick && ms == G_LAST) || (pending && ms >= MIN_G)) state_next = S_B_Y;
            end
            S_B_Y: begin
                led_b = YEL;
                if (tick && ms == Y_LAST) state_next = S_AR2;
            end
            S_PED: begin
                walk = 1'b1;
                if (tick && ms == P_LAST) state_next = S_A_G;
            end
            S_FLSH: begin
                led_a = phase ? YEL : OFF;
                led_b = phase ? YEL : OFF;
                if (!io.FLASH) state_next = S_AR2;
            end
            default: state_next = S_AR2;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ms      <= '0;
            pending <= 1'b0;
            phase   <= 1'b1;
        end else begin
            if (clr)
                ms <= '0;
            else if (state == S_FLSH && tick && ms == FL_LAST)
                ms <= '0;
            else if (tick && ms != MS_MAX)
                ms <= ms + CNT_W'(1);

            // Entering the walk phase serves the request, swallowing a press on that same edge.
            if (state_next == S_PED && state != S_PED)
                pending <= 1'b0;
            else if (io.PED_REQ && state != S_FLSH)
                pending <= 1'b1;

            if (state != S_FLSH)
                phase <= 1'b1;
            else if (tick && ms == FL_LAST)
                phase <= ~phase;
        end
    end

    assign io.LED_A       = led_a;
    assign io.LED_B       = led_b;
    assign io.PED_WALK    = walk;
    assign io.PED_PENDING = pending;
    assign io.STATE       = state;
endmodule
